// File: rtl/sumador_arbiter.sv
// Two-requester round-robin front end for a shared pipelined 4-bit adder.
// A tag pipeline follows each issue so results go back to the requester that issued them, in order.
module sumador_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic [3:0] add_dataA,
  output logic [3:0] add_dataB,
  output logic       add_valid,
  input  logic [3:0] add_sum,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [3:0] rsp0_sum,
  output logic [3:0] rsp1_sum,
  output logic [3:0] rsp0_idx,
  output logic [3:0] rsp1_idx,
  output logic       last_grant
);

  logic       ptr_q, ptr_d;
  logic       last_grant_q, last_grant_d;
  logic       add_valid_q, add_valid_d;
  logic [3:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic       iss_id_q, iss_id_d;
  logic [3:0] iss_idx_q, iss_idx_d;
  logic [3:0] idx0_q, idx0_d, idx1_q, idx1_d;

  logic [LATENCY-1:0]      tag_v_q;
  logic [LATENCY-1:0]      tag_id_q;
  logic [LATENCY-1:0][3:0] tag_idx_q;

  logic       rsp0_valid_q, rsp1_valid_q;
  logic [3:0] rsp0_sum_q, rsp1_sum_q, rsp0_idx_q, rsp1_idx_q;

  logic tail_v, tail_id;
  logic [3:0] tail_idx;
  logic xfer;

  // Grant: the pointer only matters when both requesters are valid.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset) begin
      if (req0_valid && (!req1_valid || !ptr_q)) req0_ready = 1'b1;
      else if (req1_valid)                       req1_ready = 1'b1;
    end
  end

  assign xfer = req0_ready | req1_ready;

  always_comb begin
    ptr_d        = ptr_q;
    last_grant_d = last_grant_q;
    add_valid_d  = xfer;
    add_a_d      = 4'd0;
    add_b_d      = 4'd0;
    iss_id_d     = 1'b0;
    iss_idx_d    = 4'd0;
    idx0_d       = idx0_q;
    idx1_d       = idx1_q;
    if (req0_ready) begin
      ptr_d        = 1'b1;
      last_grant_d = 1'b0;
      add_a_d      = req0_a;
      add_b_d      = req0_b;
      iss_idx_d    = idx0_q;
      idx0_d       = idx0_q + 4'd1;
    end else if (req1_ready) begin
      ptr_d        = 1'b0;
      last_grant_d = 1'b1;
      add_a_d      = req1_a;
      add_b_d      = req1_b;
      iss_id_d     = 1'b1;
      iss_idx_d    = idx1_q;
      idx1_d       = idx1_q + 4'd1;
    end
  end

  assign tail_v   = tag_v_q[LATENCY-1];
  assign tail_id  = tag_id_q[LATENCY-1];
  assign tail_idx = tag_idx_q[LATENCY-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q        <= 1'b0;
      last_grant_q <= 1'b0;
      add_valid_q  <= 1'b0;
      add_a_q      <= 4'd0;
      add_b_q      <= 4'd0;
      iss_id_q     <= 1'b0;
      iss_idx_q    <= 4'd0;
      idx0_q       <= 4'd0;
      idx1_q       <= 4'd0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      tag_idx_q    <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_sum_q   <= 4'd0;
      rsp1_sum_q   <= 4'd0;
      rsp0_idx_q   <= 4'd0;
      rsp1_idx_q   <= 4'd0;
    end else begin
      ptr_q        <= ptr_d;
      last_grant_q <= last_grant_d;
      add_valid_q  <= add_valid_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      iss_id_q     <= iss_id_d;
      iss_idx_q    <= iss_idx_d;
      idx0_q       <= idx0_d;
      idx1_q       <= idx1_d;
      // The issue register is the first stage; the tags cover the adder's LATENCY stages.
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      tag_v_q[0]   <= add_valid_q;
      tag_id_q[0]  <= iss_id_q;
      tag_idx_q[0] <= iss_idx_q;
      rsp0_valid_q <= tail_v && !tail_id;
      rsp1_valid_q <= tail_v && tail_id;
      if (tail_v && !tail_id) begin
        rsp0_sum_q <= add_sum;
        rsp0_idx_q <= tail_idx;
      end
      if (tail_v && tail_id) begin
        rsp1_sum_q <= add_sum;
        rsp1_idx_q <= tail_idx;
      end
    end
  end

  assign add_valid  = add_valid_q;
  assign add_dataA  = add_a_q;
  assign add_dataB  = add_b_q;
  assign last_grant = last_grant_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_sum   = rsp0_sum_q;
  assign rsp1_sum   = rsp1_sum_q;
  assign rsp0_idx   = rsp0_idx_q;
  assign rsp1_idx   = rsp1_idx_q;

endmodule

// File: tb/tb_sumador_arbiter.sv
// Scoreboard bench for sumador_arbiter: directed vectors push expected issues/responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_sumador_arbiter;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] add_dataA, add_dataB, add_sum;
  logic       add_valid;
  logic       rsp0_valid, rsp1_valid;
  logic [3:0] rsp0_sum, rsp1_sum, rsp0_idx, rsp1_idx;
  logic       last_grant;

  sumador_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .add_dataA(add_dataA), .add_dataB(add_dataB), .add_valid(add_valid),
    .add_sum(add_sum),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_sum(rsp0_sum), .rsp1_sum(rsp1_sum),
    .rsp0_idx(rsp0_idx), .rsp1_idx(rsp1_idx),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  // Shared adder model; bubbles return 4'hF so an ignored-tag fault shows up.
  logic [3:0] sum_pipe [LAT] = '{default: 4'd0};
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) sum_pipe[i] <= sum_pipe[i-1];
    sum_pipe[0] <= add_valid ? 4'(add_dataA + add_dataB) : 4'hF;
  end
  assign add_sum = sum_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic v; logic [3:0] a; logic [3:0] b; logic lg; } add_t;
  typedef struct { logic [3:0] sum; logic [3:0] idx; int due; } rsp_t;
  add_t aq[$];
  rsp_t rq0[$], rq1[$];

  int n_checks = 0, n_pass = 0;
  logic [3:0] idx0_m = 0, idx1_m = 0;
  logic       exp_lg = 0;
  logic [3:0] hold0_sum = 0, hold0_idx = 0, hold1_sum = 0, hold1_idx = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                       input logic e0, input logic e1);
    add_t it;
    rsp_t r;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    check(req0_ready === e0, "req0_ready", int'(req0_ready), int'(e0));
    check(req1_ready === e1, "req1_ready", int'(req1_ready), int'(e1));
    if (e0) begin
      exp_lg = 1'b0;
      it = '{1'b1, a0, b0, 1'b0};
      r = '{4'(a0 + b0), idx0_m, cyc + 2 + LAT};
      rq0.push_back(r);
      idx0_m++;
    end else if (e1) begin
      exp_lg = 1'b1;
      it = '{1'b1, a1, b1, 1'b1};
      r = '{4'(a1 + b1), idx1_m, cyc + 2 + LAT};
      rq1.push_back(r);
      idx1_m++;
    end else begin
      it = '{1'b0, 4'd0, 4'd0, exp_lg};
    end
    aq.push_back(it);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic clear_model();
    aq.delete(); rq0.delete(); rq1.delete();
    idx0_m = 0; idx1_m = 0; exp_lg = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    add_t a;
    rsp_t r;
    if (!reset) begin
      hold0_sum = 0; hold0_idx = 0; hold1_sum = 0; hold1_idx = 0;
    end else begin
      if (aq.size() > 0) begin
        a = aq.pop_front();
        check(add_valid === a.v, "add_valid", int'(add_valid), int'(a.v));
        check(add_dataA === a.a, "add_dataA", int'(add_dataA), int'(a.a));
        check(add_dataB === a.b, "add_dataB", int'(add_dataB), int'(a.b));
        check(last_grant === a.lg, "last_grant", int'(last_grant), int'(a.lg));
      end
      if (rsp0_valid) begin
        if (rq0.size() == 0) check(1'b0, "rsp0_unexpected", 1, 0);
        else begin
          r = rq0.pop_front();
          check(rsp0_sum === r.sum, "rsp0_sum", int'(rsp0_sum), int'(r.sum));
          check(rsp0_idx === r.idx, "rsp0_idx", int'(rsp0_idx), int'(r.idx));
          check(cyc == r.due, "rsp0_cycle", cyc, r.due);
          hold0_sum = r.sum; hold0_idx = r.idx;
        end
      end else begin
        check(rsp0_sum === hold0_sum && rsp0_idx === hold0_idx, "rsp0_hold",
              int'({rsp0_sum, rsp0_idx}), int'({hold0_sum, hold0_idx}));
      end
      if (rsp1_valid) begin
        if (rq1.size() == 0) check(1'b0, "rsp1_unexpected", 1, 0);
        else begin
          r = rq1.pop_front();
          check(rsp1_sum === r.sum, "rsp1_sum", int'(rsp1_sum), int'(r.sum));
          check(rsp1_idx === r.idx, "rsp1_idx", int'(rsp1_idx), int'(r.idx));
          check(cyc == r.due, "rsp1_cycle", cyc, r.due);
          hold1_sum = r.sum; hold1_idx = r.idx;
        end
      end else begin
        check(rsp1_sum === hold1_sum && rsp1_idx === hold1_idx, "rsp1_hold",
              int'({rsp1_sum, rsp1_idx}), int'({hold1_sum, hold1_idx}));
      end
    end
  end

  task automatic check_cleared(input string tag);
    check(add_valid === 1'b0, {tag, "_add_valid"}, int'(add_valid), 0);
    check(add_dataA === 4'd0 && add_dataB === 4'd0, {tag, "_add_data"},
          int'({add_dataA, add_dataB}), 0);
    check(rsp0_valid === 1'b0 && rsp1_valid === 1'b0, {tag, "_rsp_valid"},
          int'({rsp0_valid, rsp1_valid}), 0);
    check(rsp0_sum === 4'd0 && rsp0_idx === 4'd0 && rsp1_sum === 4'd0 && rsp1_idx === 4'd0,
          {tag, "_rsp_data"}, int'({rsp0_sum, rsp0_idx, rsp1_sum, rsp1_idx}), 0);
    check(last_grant === 1'b0, {tag, "_last_grant"}, int'(last_grant), 0);
    check(req0_ready === 1'b0 && req1_ready === 1'b0, {tag, "_ready"},
          int'({req0_ready, req1_ready}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0t expected < 200000", $time);
    $fatal(1);
  end

  initial begin
    // Reset state, with both requesters pushing while reset is low.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_cleared("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Single req0 3+4 -> issue next cycle, rsp0 7 idx 0 four cycles later.
    drive(1, 4'd3, 4'd4, 0, 4'd0, 4'd0, 1, 0);
    idle(5);
    // Transfers separated by bubbles.
    drive(0, 4'd0, 4'd0, 1, 4'd2, 4'd2, 0, 1);
    idle(1);
    drive(0, 4'd0, 4'd0, 1, 4'd1, 4'd1, 0, 1);
    idle(1);
    // 9+9 wraps to 2.
    drive(1, 4'd9, 4'd9, 0, 4'd0, 4'd0, 1, 0);
    idle(1);
    // Pointer now favours req1.
    drive(1, 4'd1, 4'd1, 1, 4'd2, 4'd2, 0, 1);
    idle(5);

    // Both valid from reset: 0,1,0,1.
    do_reset();
    drive(1, 4'd1, 4'd2, 1, 4'd5, 4'd6, 1, 0);
    drive(1, 4'd1, 4'd2, 1, 4'd5, 4'd6, 0, 1);
    drive(1, 4'd3, 4'd4, 1, 4'd7, 4'd8, 1, 0);
    drive(1, 4'd3, 4'd4, 1, 4'd7, 4'd8, 0, 1);
    idle(6);

    // 17 back-to-back req1 transfers: idx wraps 15 -> 0.
    do_reset();
    for (int i = 0; i < 17; i++) drive(0, 4'd0, 4'd0, 1, 4'(i), 4'd1, 0, 1);
    idle(6);

    // Asynchronous reset with two transactions in flight.
    do_reset();
    drive(1, 4'd5, 4'd5, 0, 4'd0, 4'd0, 1, 0);
    drive(0, 4'd0, 4'd0, 1, 4'd6, 4'd7, 0, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_cleared("async_reset");
    clear_model();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(8);
    drive(1, 4'd2, 4'd3, 0, 4'd0, 4'd0, 1, 0);
    idle(6);

    @(negedge clk);
    check(rq0.size() == 0, "rsp0_outstanding", rq0.size(), 0);
    check(rq1.size() == 0, "rsp1_outstanding", rq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
